// File: rtl/md_seq_if.sv
// Issue/result bundle between the E stage and the multiply/divide sequencer.
// The E stage drives the master side; md_seq implements the slave side.
interface md_seq_if;
  logic        op_valid;
  logic [2:0]  op;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic        cancel;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (
    output op_valid, op, rs_val, rt_val, cancel,
    input  busy, done, hi, lo
  );

  modport slave (
    input  op_valid, op, rs_val, rt_val, cancel,
    output busy, done, hi, lo
  );
endinterface

// File: rtl/md_seq.sv
// HI/LO multiply/divide sequencer: fixed-latency mult/div with flush abort.
// Define MD_SEQ_MADD_EN to add MADD/MSUB (ops 6/7) accumulating into {hi,lo}.
module md_seq #(
  parameter int unsigned MULT_LAT = 5,
  parameter int unsigned DIV_LAT  = 10
) (
  input logic     clk,
  input logic     reset,
  md_seq_if.slave md
);

  typedef enum logic {
    S_IDLE,
    S_RUN
  } state_e;

  typedef enum logic [2:0] {
    OP_MULT  = 3'd0,
    OP_MULTU = 3'd1,
    OP_DIV   = 3'd2,
    OP_DIVU  = 3'd3,
    OP_MTHI  = 3'd4,
    OP_MTLO  = 3'd5,
    OP_MADD  = 3'd6,
    OP_MSUB  = 3'd7
  } op_e;

`ifdef MD_SEQ_MADD_EN
  typedef enum logic [1:0] {
    ACC_NONE,
    ACC_ADD,
    ACC_SUB
  } acc_e;
`endif

  localparam logic [3:0] MULT_CNT = 4'(MULT_LAT - 1);
  localparam logic [3:0] DIV_CNT  = 4'(DIV_LAT - 1);

  state_e      state_q;
  logic [3:0]  cnt_q;
  logic        busy_q;
  logic        done_q;
  logic [31:0] hi_q;
  logic [31:0] lo_q;
  logic [31:0] pend_hi_q;
  logic [31:0] pend_lo_q;
`ifdef MD_SEQ_MADD_EN
  acc_e        acc_q;
`endif

  op_e         op_in;
  logic        issue_ok;
  logic [63:0] prod;
  logic [31:0] quot;
  logic [31:0] rem;

  assign op_in    = op_e'(md.op);
  assign issue_ok = (state_q == S_IDLE) && md.op_valid && !md.cancel;

  // ---------------------------------------------------------------------------
  // Multiplier: full 64-bit product, sign-extended operands unless MULTU.
  // ---------------------------------------------------------------------------
  logic [63:0] rs_ext;
  logic [63:0] rt_ext;

  always_comb begin
    // NOTE: every combinational output gets a default first so no latch is inferred.
    rs_ext = {32'd0, md.rs_val};
    rt_ext = {32'd0, md.rt_val};
    if (op_in != OP_MULTU) begin
      rs_ext = {{32{md.rs_val[31]}}, md.rs_val};
      rt_ext = {{32{md.rt_val[31]}}, md.rt_val};
    end
    prod = rs_ext * rt_ext;
  end

  // ---------------------------------------------------------------------------
  // Divider: magnitude divide, then restore signs. Quotient truncates toward
  // zero and the remainder takes the dividend's sign; MIN/-1 wraps to MIN.
  // ---------------------------------------------------------------------------
  logic        div_signed;
  logic        rs_neg;
  logic        rt_neg;
  logic [31:0] rs_mag;
  logic [31:0] rt_mag;
  logic [31:0] q_mag;
  logic [31:0] r_mag;

  always_comb begin
    div_signed = (op_in == OP_DIV);
    rs_neg     = div_signed & md.rs_val[31];
    rt_neg     = div_signed & md.rt_val[31];
    rs_mag     = rs_neg ? -md.rs_val : md.rs_val;
    rt_mag     = rt_neg ? -md.rt_val : md.rt_val;
    q_mag      = 32'd0;
    r_mag      = 32'd0;
    quot       = 32'hFFFF_FFFF;
    rem        = md.rs_val;
    if (md.rt_val != 32'd0) begin
      q_mag = rs_mag / rt_mag;
      r_mag = rs_mag % rt_mag;
      quot  = (rs_neg ^ rt_neg) ? -q_mag : q_mag;
      rem   = rs_neg ? -r_mag : r_mag;
    end
  end

  // ---------------------------------------------------------------------------
  // Sequencer FSM with registered outputs.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= 4'd0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      hi_q      <= 32'd0;
      lo_q      <= 32'd0;
      // NOTE: pending result registers are reset too, so a flushed op never leaves X behind.
      pend_hi_q <= 32'd0;
      pend_lo_q <= 32'd0;
`ifdef MD_SEQ_MADD_EN
      acc_q     <= ACC_NONE;
`endif
    end else begin
      // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (issue_ok) begin
            case (op_in)
              OP_MULT, OP_MULTU: begin
                {pend_hi_q, pend_lo_q} <= prod;
                cnt_q   <= MULT_CNT;
                state_q <= S_RUN;
                busy_q  <= 1'b1;
`ifdef MD_SEQ_MADD_EN
                acc_q   <= ACC_NONE;
`endif
              end
              OP_DIV, OP_DIVU: begin
                pend_hi_q <= rem;
                pend_lo_q <= quot;
                cnt_q     <= DIV_CNT;
                state_q   <= S_RUN;
                busy_q    <= 1'b1;
`ifdef MD_SEQ_MADD_EN
                acc_q     <= ACC_NONE;
`endif
              end
              OP_MTHI: hi_q <= md.rs_val;
              OP_MTLO: lo_q <= md.rs_val;
`ifdef MD_SEQ_MADD_EN
              OP_MADD, OP_MSUB: begin
                // Product is captured now; the accumulate uses {hi,lo} at commit.
                {pend_hi_q, pend_lo_q} <= prod;
                cnt_q   <= MULT_CNT;
                state_q <= S_RUN;
                busy_q  <= 1'b1;
                acc_q   <= (op_in == OP_MADD) ? ACC_ADD : ACC_SUB;
              end
`endif
              default: ;
            endcase
          end
        end

        S_RUN: begin
          if (md.cancel) begin
            // Flush wins over completion: HI/LO keep their pre-issue values.
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            busy_q  <= 1'b0;
`ifdef MD_SEQ_MADD_EN
            acc_q   <= ACC_NONE;
`endif
          end else if (cnt_q == 4'd0) begin
`ifdef MD_SEQ_MADD_EN
            case (acc_q)
              ACC_ADD: {hi_q, lo_q} <= {hi_q, lo_q} + {pend_hi_q, pend_lo_q};
              ACC_SUB: {hi_q, lo_q} <= {hi_q, lo_q} - {pend_hi_q, pend_lo_q};
              default: {hi_q, lo_q} <= {pend_hi_q, pend_lo_q};
            endcase
            acc_q   <= ACC_NONE;
`else
            {hi_q, lo_q} <= {pend_hi_q, pend_lo_q};
`endif
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end

        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign md.busy = busy_q;
  assign md.done = done_q;
  assign md.hi   = hi_q;
  assign md.lo   = lo_q;

endmodule
